// File: rtl/register32_rr_arbiter.sv
// register32_rr_arbiter
//   Round-robin write arbiter sharing one WIDTH-bit register among four
//   requesters. One arbitration per IDLE cycle; the winner is acknowledged
//   for one WRITE cycle, at the end of which its data slice is loaded.
//
// Ports
//   clk       rising-edge clock
//   reset_n   synchronous active-low reset
//   req       per-requester write request (bit i = requester i)
//   wdata     packed write data; requester i uses [i*WIDTH +: WIDTH]
//   ack       one-hot acknowledge, high during the winner's WRITE cycle
//   q         shared register contents
//   owner     requester index of the last completed write
//   valid     at least one write has completed since reset
//   busy      FSM is in WRITE
//   wr_count  completed writes since reset, modulo 256
module register32_rr_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] wdata,
  output logic [3:0]         ack,
  output logic [WIDTH-1:0]   q,
  output logic [1:0]         owner,
  output logic               valid,
  output logic               busy,
  output logic [7:0]         wr_count
);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [1:0]       ptr, ptr_n;
  logic [1:0]       idx, idx_n;
  logic [3:0]       ack_n;
  logic [WIDTH-1:0] q_n;
  logic [1:0]       owner_n;
  logic             valid_n;
  logic             busy_n;
  logic [7:0]       wr_count_n;

  // Round-robin pick: first requester at or after ptr (mod 4).
  logic       found;
  logic [1:0] win;
  logic [1:0] cand;

  always_comb begin
    found = 1'b0;
    win   = ptr;
    cand  = ptr;
    for (int unsigned k = 0; k < 4; k++) begin
      cand = ptr + k[1:0];
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    idx_n      = idx;
    ack_n      = ack;
    q_n        = q;
    owner_n    = owner;
    valid_n    = valid;
    busy_n     = busy;
    wr_count_n = wr_count;

    case (state)
      IDLE: begin
        if (found) begin
          idx_n   = win;
          ack_n   = 4'b0001 << win;
          busy_n  = 1'b1;
          state_n = WRITE;
        end
      end
      WRITE: begin
        // Data is sampled at the edge ending WRITE, not at selection.
        q_n        = wdata[idx*WIDTH +: WIDTH];
        owner_n    = idx;
        valid_n    = 1'b1;
        wr_count_n = wr_count + 8'd1;
        ptr_n      = idx + 2'd1;
        ack_n      = '0;
        busy_n     = 1'b0;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Reset takes priority, so a reset on the edge ending WRITE drops the load.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      ptr      <= '0;
      idx      <= '0;
      ack      <= '0;
      q        <= '0;
      owner    <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      wr_count <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      idx      <= idx_n;
      ack      <= ack_n;
      q        <= q_n;
      owner    <= owner_n;
      valid    <= valid_n;
      busy     <= busy_n;
      wr_count <= wr_count_n;
    end
  end

endmodule
